// File: rtl/pipe_operand_sequencer.sv
// Operand FIFO, credit-gated issue into a fixed-latency pipeline, and an in-order result FIFO.
// A result slot is reserved at issue time because the pipeline cannot be stalled.
module pipe_operand_sequencer #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  parameter int LAT   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [W-1:0] wr_a,
  input  logic [W-1:0] wr_b,
  input  logic [W-1:0] wr_c,
  input  logic [W-1:0] wr_d,
  output logic         op_valid,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [W-1:0] op_c,
  output logic [W-1:0] op_d,
  input  logic [W-1:0] pipe_f,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
  } tuple_t;

  tuple_t        op_mem [DEPTH];
  logic [W-1:0]  res_mem [DEPTH];

  logic [AW-1:0] op_wptr, op_rptr, res_wptr, res_rptr;
  logic [CW-1:0] op_count, res_count, inflight;
  logic [CW:0]   credit_used;
  logic [LAT-1:0] vld_sr, vld_sr_next;
  logic          push_op, issue, capture, pop_res;

  assign wr_ready    = (op_count < DEPTH_CNT);
  assign push_op     = wr_valid && wr_ready;
  // Registered counts only: a result popped this cycle frees its credit next cycle.
  assign credit_used = {1'b0, res_count} + {1'b0, inflight};
  assign issue       = (op_count != '0) && (credit_used < {1'b0, DEPTH_CNT});
  assign capture     = vld_sr[LAT-1];
  assign rd_valid    = (res_count != '0);
  assign pop_res     = rd_valid && rd_ready;
  assign rd_data     = rd_valid ? res_mem[res_rptr] : '0;
  assign busy        = (op_count != '0) || (inflight != '0) || (res_count != '0);

  if (LAT > 1) begin : g_sr_multi
    assign vld_sr_next = {vld_sr[LAT-2:0], op_valid};
  end else begin : g_sr_single
    assign vld_sr_next = op_valid;
  end

  // NOTE: the storage arrays have no reset; the counts alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_op) op_mem[op_wptr]   <= '{a: wr_a, b: wr_b, c: wr_c, d: wr_d};
    if (capture) res_mem[res_wptr] <= pipe_f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wptr   <= '0;
      op_rptr   <= '0;
      op_count  <= '0;
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      op_d      <= '0;
      vld_sr    <= '0;
      inflight  <= '0;
      res_wptr  <= '0;
      res_rptr  <= '0;
      res_count <= '0;
    end else begin
      if (push_op) op_wptr <= op_wptr + 1'b1;
      if (issue) begin
        op_rptr <= op_rptr + 1'b1;
        op_a    <= op_mem[op_rptr].a;
        op_b    <= op_mem[op_rptr].b;
        op_c    <= op_mem[op_rptr].c;
        op_d    <= op_mem[op_rptr].d;
      end
      op_valid <= issue;
      op_count <= op_count + CW'(push_op) - CW'(issue);

      vld_sr   <= vld_sr_next;
      inflight <= inflight + CW'(issue) - CW'(capture);

      if (capture) res_wptr <= res_wptr + 1'b1;
      if (pop_res) res_rptr <= res_rptr + 1'b1;
      res_count <= res_count + CW'(capture) - CW'(pop_res);
    end
  end

endmodule
